fft_stage_ctrl: RTL and testbench

Sequencer for the 256-point radix-4 DIF FFT core. It steps the four butterfly stages over the in-place data cache and drives the stage, sub_stage and invbit_done flags consumed by the twiddle-factor ROM. For each butterfly it issues four read addresses, and it generates the matching write-back addresses delayed by the butterfly pipeline latency. After stage 4 it runs a digit-reversed readout of all 256 results.

---
 rtl/fft_stage_ctrl_pkg.sv | 52 +++++
 rtl/fft_delay_line.sv | 30 +++
 rtl/fft_stage_ctrl.sv | 183 ++++++++++++++++++
 tb/tb_fft_stage_ctrl.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/fft_stage_ctrl_pkg.sv
// rtl/fft_stage_ctrl_pkg.sv - shared widths, stage codes, state encoding and address helpers
// Contents:
//   STAGE_WID, SUB_STAGE_WID, CACHE_ADDR_WID : field widths
//   STAGE1..STAGE4                           : stage codes seen by the twiddle ROM
//   state_t                                  : sequencer states
//   bf_base / bf_span                        : radix-4 DIF butterfly base address and leg span
//   digit_rev                                : base-4 digit reversal of a cache address
package fft_stage_ctrl_pkg;

  localparam int STAGE_WID      = 2;
  localparam int SUB_STAGE_WID  = 6;
  localparam int CACHE_ADDR_WID = 8;

  localparam logic [STAGE_WID-1:0] STAGE1 = 2'd0;
  localparam logic [STAGE_WID-1:0] STAGE2 = 2'd1;
  localparam logic [STAGE_WID-1:0] STAGE3 = 2'd2;
  localparam logic [STAGE_WID-1:0] STAGE4 = 2'd3;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_RUN       = 3'd1,
    ST_DRAIN     = 3'd2,
    ST_READOUT   = 3'd3,
    ST_OUT_DRAIN = 3'd4,
    ST_DONE      = 3'd5
  } state_t;

  // Base address: a zero base-4 digit is inserted at the position of the
  // stage's span, so the four legs b + K*span never carry into the next group.
  function automatic logic [7:0] bf_base(input logic [1:0] stage, input logic [5:0] sub);
    case (stage)
      STAGE1:  bf_base = {2'b00, sub};
      STAGE2:  bf_base = {sub[5:4], 2'b00, sub[3:0]};
      STAGE3:  bf_base = {sub[5:2], 2'b00, sub[1:0]};
      default: bf_base = {sub, 2'b00};
    endcase
  endfunction

  function automatic logic [7:0] bf_span(input logic [1:0] stage);
    case (stage)
      STAGE1:  bf_span = 8'd64;
      STAGE2:  bf_span = 8'd16;
      STAGE3:  bf_span = 8'd4;
      default: bf_span = 8'd1;
    endcase
  endfunction

  function automatic logic [7:0] digit_rev(input logic [7:0] n);
    digit_rev = {n[1:0], n[3:2], n[5:4], n[7:6]};
  endfunction

endpackage

// File: rtl/fft_delay_line.sv
// rtl/fft_delay_line.sv - fixed-depth shift register with synchronous clear
// Ports:
//   i_clk  : clock
//   i_rst  : synchronous active-high clear of every stage
//   i_data : WIDTH-bit input word
//   o_data : i_data delayed exactly DEPTH cycles (DEPTH >= 1)
module fft_delay_line #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 1
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [WIDTH-1:0] i_data,
  output logic [WIDTH-1:0] o_data
);

  logic [WIDTH-1:0] r_pipe [DEPTH];

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int i = 0; i < DEPTH; i++) r_pipe[i] <= '0;
    end else begin
      r_pipe[0] <= i_data;
      for (int i = 1; i < DEPTH; i++) r_pipe[i] <= r_pipe[i-1];
    end
  end

  assign o_data = r_pipe[DEPTH-1];

endmodule

// File: rtl/fft_stage_ctrl.sv
// rtl/fft_stage_ctrl.sv - stage/butterfly sequencer and digit-reversed readout for a 256-point radix-4 FFT
// Ports:
//   i_clk, i_rst                : clock, synchronous active-high reset
//   i_start                     : one-cycle run request, honoured in IDLE only
//   i_out_ready                 : readout may issue this cycle
//   o_busy, o_done              : run in progress / one-cycle completion pulse
//   o_stage, o_sub_stage        : twiddle ROM selectors, valid alongside o_rd_en
//   o_invbit_done               : high while reading out in digit-reversed order
//   o_rd_en, o_rd_addr0..3      : butterfly read strobe and four leg addresses
//   o_wr_en, o_wr_addr0..3      : write-back, the read strobe/addresses delayed BF_LAT
//   o_out_rd_en, o_out_rd_addr  : readout read strobe and digit-reversed address
//   o_out_valid, o_out_index    : readout strobe and natural-order bin delayed RD_LAT
module fft_stage_ctrl
  import fft_stage_ctrl_pkg::*;
#(
  parameter int BF_LAT = 4,
  parameter int RD_LAT = 1
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  input  logic                      i_start,
  input  logic                      i_out_ready,
  output logic                      o_busy,
  output logic                      o_done,
  output logic [STAGE_WID-1:0]      o_stage,
  output logic [SUB_STAGE_WID-1:0]  o_sub_stage,
  output logic                      o_invbit_done,
  output logic                      o_rd_en,
  output logic [CACHE_ADDR_WID-1:0] o_rd_addr0,
  output logic [CACHE_ADDR_WID-1:0] o_rd_addr1,
  output logic [CACHE_ADDR_WID-1:0] o_rd_addr2,
  output logic [CACHE_ADDR_WID-1:0] o_rd_addr3,
  output logic                      o_wr_en,
  output logic [CACHE_ADDR_WID-1:0] o_wr_addr0,
  output logic [CACHE_ADDR_WID-1:0] o_wr_addr1,
  output logic [CACHE_ADDR_WID-1:0] o_wr_addr2,
  output logic [CACHE_ADDR_WID-1:0] o_wr_addr3,
  output logic                      o_out_rd_en,
  output logic [CACHE_ADDR_WID-1:0] o_out_rd_addr,
  output logic                      o_out_valid,
  output logic [CACHE_ADDR_WID-1:0] o_out_index
);

  localparam logic [7:0] BF_LAST = 8'(BF_LAT - 1);
  localparam logic [7:0] RD_LAST = 8'(RD_LAT - 1);

  state_t                     r_state;
  logic [STAGE_WID-1:0]       r_stage;
  logic [SUB_STAGE_WID-1:0]   r_sub;
  logic [7:0]                 r_n;
  logic [7:0]                 r_cnt;   // shared by DRAIN and OUT_DRAIN
  logic                       r_rd_en;
  logic                       r_busy;
  logic                       r_done;
  logic                       r_invbit;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state  <= ST_IDLE;
      r_stage  <= STAGE1;
      r_sub    <= '0;
      r_n      <= '0;
      r_cnt    <= '0;
      r_rd_en  <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_invbit <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (i_start) begin
            r_state <= ST_RUN;
            r_stage <= STAGE1;
            r_sub   <= '0;
            r_rd_en <= 1'b1;
            r_busy  <= 1'b1;
          end
        end
        ST_RUN: begin
          if (r_sub == 6'd63) begin
            r_state <= ST_DRAIN;
            r_rd_en <= 1'b0;
            r_cnt   <= '0;
          end else begin
            r_sub <= r_sub + 6'd1;
          end
        end
        ST_DRAIN: begin
          // Waiting BF_LAT idle cycles lets the stage's last write-back land
          // just before the next stage reads the same cache locations.
          if (r_cnt == BF_LAST) begin
            if (r_stage != STAGE4) begin
              r_state <= ST_RUN;
              r_stage <= r_stage + 2'd1;
              r_sub   <= '0;
              r_rd_en <= 1'b1;
            end else begin
              r_state  <= ST_READOUT;
              r_invbit <= 1'b1;
              r_n      <= '0;
            end
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end
        ST_READOUT: begin
          if (i_out_ready) begin
            r_n <= r_n + 8'd1;
            if (r_n == 8'd255) begin
              r_state <= ST_OUT_DRAIN;
              r_cnt   <= '0;
            end
          end
        end
        ST_OUT_DRAIN: begin
          if (r_cnt == RD_LAST) begin
            r_state  <= ST_DONE;
            r_busy   <= 1'b0;
            r_done   <= 1'b1;
            r_invbit <= 1'b0;
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end
        ST_DONE: begin
          r_state <= ST_IDLE;
          r_done  <= 1'b0;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  logic [7:0] w_base;
  logic [7:0] w_span;
  logic [7:0] w_span2;
  logic [7:0] w_a0, w_a1, w_a2, w_a3;
  logic       w_out_rd_en;
  logic [32:0] w_wr_dly;
  logic [8:0]  w_out_dly;

  assign w_base  = bf_base(r_stage, r_sub);
  assign w_span  = bf_span(r_stage);
  assign w_span2 = {w_span[6:0], 1'b0};

  // Addresses are zeroed while idle so reset and gaps show a clean bus.
  assign w_a0 = r_rd_en ? w_base                    : '0;
  assign w_a1 = r_rd_en ? w_base + w_span           : '0;
  assign w_a2 = r_rd_en ? w_base + w_span2          : '0;
  assign w_a3 = r_rd_en ? w_base + w_span2 + w_span : '0;

  assign w_out_rd_en = (r_state == ST_READOUT) & i_out_ready;

  fft_delay_line #(.WIDTH(33), .DEPTH(BF_LAT)) u_wr_dly (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .i_data ({r_rd_en, w_a3, w_a2, w_a1, w_a0}),
    .o_data (w_wr_dly)
  );

  fft_delay_line #(.WIDTH(9), .DEPTH(RD_LAT)) u_out_dly (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .i_data ({w_out_rd_en, r_n}),
    .o_data (w_out_dly)
  );

  assign o_busy        = r_busy;
  assign o_done        = r_done;
  assign o_stage       = r_stage;
  assign o_sub_stage   = r_sub;
  assign o_invbit_done = r_invbit;
  assign o_rd_en       = r_rd_en;
  assign o_rd_addr0    = w_a0;
  assign o_rd_addr1    = w_a1;
  assign o_rd_addr2    = w_a2;
  assign o_rd_addr3    = w_a3;
  assign {o_wr_en, o_wr_addr3, o_wr_addr2, o_wr_addr1, o_wr_addr0} = w_wr_dly;
  assign o_out_rd_en   = w_out_rd_en;
  assign o_out_rd_addr = (r_state == ST_READOUT) ? digit_rev(r_n) : '0;
  assign {o_out_valid, o_out_index} = w_out_dly;

endmodule

// File: tb/tb_fft_stage_ctrl.sv
// tb/tb_fft_stage_ctrl.sv - self-checking bench for fft_stage_ctrl
module tb_fft_stage_ctrl;

  localparam int BF_LAT = 4;
  localparam int RD_LAT = 1;
  localparam int P      = 64 + BF_LAT;
  localparam int BUDGET = 3000;

  logic       clk = 1'b0;
  logic       i_rst = 1'b1;
  logic       i_start = 1'b0;
  logic       i_out_ready = 1'b1;
  logic       o_busy, o_done, o_invbit_done, o_rd_en, o_wr_en, o_out_rd_en, o_out_valid;
  logic [1:0] o_stage;
  logic [5:0] o_sub_stage;
  logic [7:0] o_rd_addr0, o_rd_addr1, o_rd_addr2, o_rd_addr3;
  logic [7:0] o_wr_addr0, o_wr_addr1, o_wr_addr2, o_wr_addr3;
  logic [7:0] o_out_rd_addr, o_out_index;

  int n_cmp = 0;
  int n_fail = 0;

  int e_rd  [BUDGET];
  int e_ad  [BUDGET][4];
  int e_ord [BUDGET];
  int e_n   [BUDGET];

  always #5 clk = ~clk;

  fft_stage_ctrl #(.BF_LAT(BF_LAT), .RD_LAT(RD_LAT)) dut (
    .i_clk(clk), .i_rst(i_rst), .i_start(i_start), .i_out_ready(i_out_ready),
    .o_busy(o_busy), .o_done(o_done), .o_stage(o_stage), .o_sub_stage(o_sub_stage),
    .o_invbit_done(o_invbit_done), .o_rd_en(o_rd_en),
    .o_rd_addr0(o_rd_addr0), .o_rd_addr1(o_rd_addr1), .o_rd_addr2(o_rd_addr2), .o_rd_addr3(o_rd_addr3),
    .o_wr_en(o_wr_en),
    .o_wr_addr0(o_wr_addr0), .o_wr_addr1(o_wr_addr1), .o_wr_addr2(o_wr_addr2), .o_wr_addr3(o_wr_addr3),
    .o_out_rd_en(o_out_rd_en), .o_out_rd_addr(o_out_rd_addr),
    .o_out_valid(o_out_valid), .o_out_index(o_out_index)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_cmp++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
    end
  endtask

  task automatic drive(input logic st, input logic rdy, input logic rs);
    @(negedge clk);
    i_start = st;
    i_out_ready = rdy;
    i_rst = rs;
    #1;
  endtask

  // Reference: butterfly with span L = 4^(3-s) groups of 4L points.
  function automatic int bfly_addr(input int s, input int sub, input int leg);
    int L;
    L = 64 >> (2 * s);
    return (sub / L) * 4 * L + (sub % L) + leg * L;
  endfunction

  function automatic int rev4(input int n);
    return (n % 4) * 64 + ((n / 4) % 4) * 16 + ((n / 16) % 4) * 4 + (n / 64) % 4;
  endfunction

  task automatic chk_zero(input string pfx);
    chk({pfx, "_busy"}, 32'(o_busy), 0);
    chk({pfx, "_done"}, 32'(o_done), 0);
    chk({pfx, "_stage"}, 32'(o_stage), 0);
    chk({pfx, "_sub"}, 32'(o_sub_stage), 0);
    chk({pfx, "_invbit"}, 32'(o_invbit_done), 0);
    chk({pfx, "_rd_en"}, 32'(o_rd_en), 0);
    chk({pfx, "_rd_a0"}, 32'(o_rd_addr0), 0);
    chk({pfx, "_rd_a1"}, 32'(o_rd_addr1), 0);
    chk({pfx, "_rd_a2"}, 32'(o_rd_addr2), 0);
    chk({pfx, "_rd_a3"}, 32'(o_rd_addr3), 0);
    chk({pfx, "_wr_en"}, 32'(o_wr_en), 0);
    chk({pfx, "_wr_a0"}, 32'(o_wr_addr0), 0);
    chk({pfx, "_wr_a1"}, 32'(o_wr_addr1), 0);
    chk({pfx, "_wr_a2"}, 32'(o_wr_addr2), 0);
    chk({pfx, "_wr_a3"}, 32'(o_wr_addr3), 0);
    chk({pfx, "_ord_en"}, 32'(o_out_rd_en), 0);
    chk({pfx, "_ord_addr"}, 32'(o_out_rd_addr), 0);
    chk({pfx, "_ovalid"}, 32'(o_out_valid), 0);
    chk({pfx, "_oindex"}, 32'(o_out_index), 0);
  endtask

  // mode 0: out_ready always 1; 1: random; 2: repeating 1,0,0,1.
  // abort_k > 0 pulses reset at that cycle offset and stops the run.
  task automatic run_fft(input int mode, input int abort_k);
    int  ph, m_n, d_cnt, stalls, wr_cnt, nxt_idx, done_k;
    int  x_busy, x_done, x_inv, x_rd, x_stage, x_sub, x_ord, x_wr, x_ov;
    logic st, rdy, rs;
    m_n = 0; d_cnt = 0; stalls = 0; wr_cnt = 0; nxt_idx = 0; done_k = -1;
    for (int k = 0; k < BUDGET; k++) begin
      st  = (k == 0) ? 1'b1 : ($urandom_range(0, 15) == 0);
      rdy = (mode == 0) ? 1'b1 :
            (mode == 1) ? 1'($urandom_range(0, 1)) :
            ((k % 4 == 0) || (k % 4 == 3));
      rs  = (abort_k > 0 && k == abort_k);
      drive(st, rdy, rs);

      // phases: 0 idle, 1 butterflies, 2 readout, 3 readout drain, 4 done
      if (k == 0)              ph = 0;
      else if (k <= 4 * P)     ph = 1;
      else if (m_n < 256)      ph = 2;
      else if (d_cnt < RD_LAT) ph = 3;
      else                     ph = 4;

      x_busy = (ph >= 1 && ph <= 3) ? 1 : 0;
      x_done = (ph == 4) ? 1 : 0;
      x_inv  = (ph == 2 || ph == 3) ? 1 : 0;
      x_stage = (ph == 1) ? (k - 1) / P : 0;
      x_rd   = (ph == 1 && ((k - 1) % P) < 64) ? 1 : 0;
      x_sub  = (ph == 1) ? (x_rd ? (k - 1) % P : 63) : 0;
      x_ord  = (ph == 2) ? int'(rdy) : 0;
      e_rd[k]  = x_rd;
      for (int j = 0; j < 4; j++) e_ad[k][j] = x_rd ? bfly_addr(x_stage, x_sub, j) : 0;
      e_ord[k] = x_ord;
      e_n[k]   = (ph == 2) ? m_n : 0;
      x_wr = (k >= BF_LAT) ? e_rd[k - BF_LAT] : 0;
      x_ov = (k >= RD_LAT) ? e_ord[k - RD_LAT] : 0;

      chk("busy", 32'(o_busy), x_busy);
      chk("done", 32'(o_done), x_done);
      chk("invbit_done", 32'(o_invbit_done), x_inv);
      chk("rd_en", 32'(o_rd_en), x_rd);
      if (ph == 1) begin
        chk("stage", 32'(o_stage), x_stage);
        chk("sub_stage", 32'(o_sub_stage), x_sub);
      end
      if (x_rd == 1) begin
        chk("rd_addr0", 32'(o_rd_addr0), e_ad[k][0]);
        chk("rd_addr1", 32'(o_rd_addr1), e_ad[k][1]);
        chk("rd_addr2", 32'(o_rd_addr2), e_ad[k][2]);
        chk("rd_addr3", 32'(o_rd_addr3), e_ad[k][3]);
      end
      chk("wr_en", 32'(o_wr_en), x_wr);
      if (x_wr == 1) begin
        chk("wr_addr0", 32'(o_wr_addr0), e_ad[k - BF_LAT][0]);
        chk("wr_addr1", 32'(o_wr_addr1), e_ad[k - BF_LAT][1]);
        chk("wr_addr2", 32'(o_wr_addr2), e_ad[k - BF_LAT][2]);
        chk("wr_addr3", 32'(o_wr_addr3), e_ad[k - BF_LAT][3]);
      end
      chk("out_rd_en", 32'(o_out_rd_en), x_ord);
      if (x_ord == 1) chk("out_rd_addr", 32'(o_out_rd_addr), rev4(m_n));
      chk("out_valid", 32'(o_out_valid), x_ov);
      if (x_ov == 1) chk("out_index", 32'(o_out_index), e_n[k - RD_LAT]);

      // Hand-derived points from the address and readout rules.
      if (mode == 0 && k == 1) begin
        chk("s1_first_a0", 32'(o_rd_addr0), 0);
        chk("s1_first_a1", 32'(o_rd_addr1), 64);
        chk("s1_first_a2", 32'(o_rd_addr2), 128);
        chk("s1_first_a3", 32'(o_rd_addr3), 192);
      end
      if (mode == 0 && k == 1 + P + 21) begin
        chk("s2_x15_a0", 32'(o_rd_addr0), 69);
        chk("s2_x15_a3", 32'(o_rd_addr3), 117);
      end
      if (mode == 0 && k == 1 + 2 * P + 46) begin
        chk("s3_x2e_a0", 32'(o_rd_addr0), 178);
        chk("s3_x2e_a3", 32'(o_rd_addr3), 190);
      end
      if (mode == 0 && k == 1 + 3 * P + 63) begin
        chk("s4_x3f_a0", 32'(o_rd_addr0), 252);
        chk("s4_x3f_a3", 32'(o_rd_addr3), 255);
      end
      if (mode == 0 && k == 4 * P + 2)  chk("rev_n1", 32'(o_out_rd_addr), 64);
      if (mode == 0 && k == 4 * P + 28) chk("rev_n27", 32'(o_out_rd_addr), 228);

      if (o_wr_en === 1'b1) wr_cnt++;
      if (o_out_valid === 1'b1) begin
        chk("index_seq", 32'(o_out_index), nxt_idx % 256);
        nxt_idx++;
      end
      if (o_done === 1'b1 && done_k < 0) done_k = k;

      if (rs) begin
        for (int j = 0; j < 12; j++) begin
          drive(1'b0, rdy, 1'b0);
          chk_zero("post_rst");
        end
        break;
      end
      if (ph == 4) break;

      if (ph == 2 && rdy) m_n++;
      else if (ph == 2) stalls++;
      if (ph == 3) d_cnt++;
    end
    if (abort_k == 0) begin
      chk("done_seen", 32'(done_k >= 0), 1);
      chk("done_cycle", 32'(done_k), 2 + 4 * P + 255 + RD_LAT + stalls);
      chk("wr_count", 32'(wr_cnt), 256);
      chk("index_count", 32'(nxt_idx), 256);
      if (mode == 0) chk("done_530", 32'(done_k), 530);
    end
  endtask

  initial begin
    repeat (3) drive(1'b0, 1'b1, 1'b1);
    drive(1'b0, 1'b1, 1'b0);
    chk_zero("reset");
    run_fft(0, 0);
    run_fft(2, 0);
    run_fft(1, 2 * P + 1 + int'($urandom_range(0, 63)));
    run_fft(1, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
